// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial restoring divider: FSM state encoding
// and the quotient bit pattern reported for a divide by zero.
package serial_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Every quotient bit is set on a divide by zero (all-ones quotient).
  localparam logic DIVZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/serial_divider_if.sv
// Start/Busy/Done handshake bundle between a caller and the serial divider.
interface serial_divider_if #(
  parameter int WIDTH = 4
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivZero;

  modport master (
    output Start, A, B,
    input  Busy, Done, Quotient, Remainder, DivZero
  );

  modport slave (
    input  Start, A, B,
    output Busy, Done, Quotient, Remainder, DivZero
  );
endinterface

// File: rtl/serial_divider_step.sv
// One combinational iteration of unsigned restoring division: shift the
// partial remainder/quotient pair left, trial-subtract the divisor and keep
// the difference only when it does not borrow.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   p_nxt,
  output logic [WIDTH-1:0] q_nxt
);
  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] t;

  // Trial subtraction; the MSB of the WIDTH+1-bit difference is the borrow.
  always_comb begin
    p_sh  = {p[WIDTH-1:0], q[WIDTH-1]};
    t     = p_sh - {1'b0, b};
    q_nxt = {q[WIDTH-2:0], ~t[WIDTH]};
    p_nxt = t[WIDTH] ? p_sh : t;
  end
endmodule

// File: rtl/serial_divider.sv
// Multi-cycle unsigned restoring divider (DIVU unit): one quotient bit per
// clock behind a Start/Busy/Done handshake. Divide by zero finishes at once.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  serial_divider_if.slave bus
);
  localparam int             CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH:0]     p_q, p_nxt;
  logic [WIDTH-1:0]   q_q, q_nxt, b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   quot_q, rem_q;
  logic               dz_q;
  logic               start_ok, start_dz, last_step;

  assign start_ok  = (state_q == S_IDLE) && bus.Start && (bus.B != '0);
  assign start_dz  = (state_q == S_IDLE) && bus.Start && (bus.B == '0);
  assign last_step = (state_q == S_RUN) && (cnt_q == LAST);

  div_step #(.WIDTH(WIDTH)) u_step (
    .p     (p_q),
    .q     (q_q),
    .b     (b_q),
    .p_nxt (p_nxt),
    .q_nxt (q_nxt)
  );

  // Next-state decode: a zero divisor skips RUN entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.Start) state_d = (bus.B == '0) ? S_FIN : S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; Reset abandons any operation in flight.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Step counter; never wraps inside one operation.
  always_ff @(posedge Clk) begin
    if (Reset)                  cnt_q <= '0;
    else if (start_ok)          cnt_q <= '0;
    else if (state_q == S_RUN)  cnt_q <= cnt_q + CNT_W'(1);
  end

  // Iteration datapath: operands captured on accept, one step per RUN cycle.
  always_ff @(posedge Clk) begin
    if (start_ok) begin
      q_q <= bus.A;
      b_q <= bus.B;
      p_q <= '0;
    end else if (state_q == S_RUN) begin
      q_q <= q_nxt;
      p_q <= p_nxt;
    end
  end

  // Result registers: written only on entry to FIN, held until the next one.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
    end else if (start_dz) begin
      quot_q <= {WIDTH{DIVZERO_Q_BIT}};
      rem_q  <= bus.A;
      dz_q   <= 1'b1;
    end else if (last_step) begin
      quot_q <= q_nxt;
      rem_q  <= p_nxt[WIDTH-1:0];
      dz_q   <= 1'b0;
    end
  end

  assign bus.Busy      = (state_q == S_RUN);
  assign bus.Done      = (state_q == S_FIN);
  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.DivZero   = dz_q;
endmodule
